// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring mantissa division with RNE rounding,
// special-case bypass and a five-bit exception vector, behind valid/ready handshakes.
module fp_div_iter #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [4:0]   flags,
    output logic [2:0]   state_dbg
);
    // Handshake: a transfer happens on any rising edge where valid and ready are both high;
    // in_ready is high only in IDLE and out_valid only in DONE, where result/flags hold still.

    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 4);
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] MAX_E = EW'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(MAN_W + 2);
    localparam logic [W-1:0]         QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [W-1:0]           a_r, b_r;
    logic                   sign;
    logic signed [EW-1:0]   exp_r;
    logic [MAN_W+1:0]       rem;
    logic [MAN_W:0]         div;
    logic [MAN_W+2:0]       q;
    logic [CNT_W-1:0]       cnt;

    assign in_ready  = (state == S_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state == S_DONE);
    assign state_dbg = state;

    // Operand unpack and special-case classification (subnormals count as zero)
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 sgn_calc;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                 special;
    logic [W-1:0]         spec_res;
    logic [4:0]           spec_flags;
    logic signed [EW-1:0] exp_calc;

    always_comb begin
        ea       = a_r[W-2:MAN_W];
        eb       = b_r[W-2:MAN_W];
        fa       = a_r[MAN_W-1:0];
        fb       = b_r[MAN_W-1:0];
        sgn_calc = a_r[W-1] ^ b_r[W-1];
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        a_inf    = (ea == '1) && (fa == '0);
        b_inf    = (eb == '1) && (fb == '0);
        a_nan    = (ea == '1) && (fa != '0);
        b_nan    = (eb == '1) && (fb != '0);
        exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = QNAN;
            spec_flags = 5'b10000;
        end else if (a_inf) begin
            spec_res = {sgn_calc, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            spec_res   = {sgn_calc, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags = 5'b01000;
        end else if (a_zero || b_inf) begin
            spec_res = {sgn_calc, {(W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    // One restoring-division step
    logic             ge;
    logic [MAN_W+1:0] rem_sel;
    logic [MAN_W+1:0] rem_next;

    always_comb begin
        ge       = (rem >= {1'b0, div});
        rem_sel  = ge ? (rem - {1'b0, div}) : rem;
        rem_next = rem_sel << 1;
    end

    // Normalise, round to nearest even, then clamp to the representable range
    logic [MAN_W+2:0]     qn;
    logic signed [EW-1:0] en, ef;
    logic [MAN_W:0]       mant;
    logic                 g_bit, r_bit, s_bit, inc, inexact;
    logic [MAN_W+1:0]     sum;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         rnd_res;
    logic [4:0]           rnd_flags;

    always_comb begin
        if (q[MAN_W+2]) begin
            qn = q;
            en = exp_r;
        end else begin
            qn = q << 1;
            en = exp_r - EW'(1);
        end
        mant    = qn[MAN_W+2:2];
        g_bit   = qn[1];
        r_bit   = qn[0];
        s_bit   = (rem != '0);
        inexact = g_bit | r_bit | s_bit;
        inc     = g_bit & (r_bit | s_bit | mant[0]);
        sum     = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
        if (sum[MAN_W+1]) begin
            frac = sum[MAN_W:1];
            ef   = en + EW'(1);
        end else begin
            frac = sum[MAN_W-1:0];
            ef   = en;
        end

        if (ef >= MAX_E) begin
            rnd_res   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags = 5'b00101;
        end else if (ef <= EW'(0)) begin
            rnd_res   = {sign, {(W-1){1'b0}}};
            rnd_flags = 5'b00011;
        end else begin
            rnd_res   = {sign, ef[EXP_W-1:0], frac};
            rnd_flags = {4'b0000, inexact};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_PREP;
            S_PREP:  state_next = special ? S_DONE : S_ITER;
            S_ITER:  if (cnt == LAST) state_next = S_ROUND;
            S_ROUND: state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sign   <= 1'b0;
            exp_r  <= '0;
            rem    <= '0;
            div    <= '0;
            q      <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                    end
                end
                S_PREP: begin
                    sign  <= sgn_calc;
                    exp_r <= exp_calc;
                    rem   <= {2'b01, fa};
                    div   <= {1'b1, fb};
                    q     <= '0;
                    cnt   <= '0;
                    if (special) begin
                        result <= spec_res;
                        flags  <= spec_flags;
                    end
                end
                S_ITER: begin
                    rem <= rem_next;
                    q   <= {q[MAN_W+1:0], ge};
                    cnt <= cnt + CNT_W'(1);
                end
                S_ROUND: begin
                    result <= rnd_res;
                    flags  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter (binary32): a reference quotient model built on wide
// integer division feeds an expected queue that a negedge monitor checks every DONE cycle.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] exp_q[$];

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, expv);
    endtask

    // Reference: returns {flags, result} from IEEE rules using exact integer quotient
    function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y);
        logic       s;
        int         ex, ey, e;
        logic [22:0] fx, fy;
        logic       xz, yz, xi, yi, xn, yn;
        logic [63:0] num, qq, rr, man;
        logic       g, st, incr;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);  ey = int'(y[30:23]);
        fx = x[22:0];         fy = y[22:0];
        xz = (ex == 0);       yz = (ey == 0);
        xi = (ex == 255) && (fx == 0);  yi = (ey == 255) && (fy == 0);
        xn = (ex == 255) && (fx != 0);  yn = (ey == 255) && (fy != 0);
        if (xn || yn) return {5'b00000, 32'h7FC00000};
        if ((xz && yz) || (xi && yi)) return {5'b10000, 32'h7FC00000};
        if (xi) return {5'b00000, s, 8'hFF, 23'd0};
        if (yz) return {5'b01000, s, 8'hFF, 23'd0};
        if (xz || yi) return {5'b00000, s, 31'd0};
        num = {40'd1, fx} << 26;
        qq  = num / {40'd1, fy};
        rr  = num % {40'd1, fy};
        e   = ex - ey + 127;
        if (qq >= (64'd1 << 26)) begin
            man = qq >> 3;  g = qq[2];  st = (qq[1:0] != 0) || (rr != 0);
        end else begin
            man = qq >> 2;  g = qq[1];  st = qq[0] || (rr != 0);  e = e - 1;
        end
        incr = g && (st || man[0]);
        man  = man + {63'd0, incr};
        if (man == (64'd1 << 24)) begin
            man = man >> 1;  e = e + 1;
        end
        if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {5'b00011, s, 31'd0};
        return {4'b0000, g || st, s, e[7:0], man[22:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                check("mon_result", result, exp_q[0][31:0]);
                check("mon_flags", {27'd0, flags}, {27'd0, exp_q[0][36:32]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                          input logic [4:0] ef, input int el, input int hold);
        int lat;
        wait_idle();
        a = x;  b = y;  in_valid = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check($sformatf("latency_%h_%h", x, y), lat, el);
        check($sformatf("result_%h_%h", x, y), result, er);
        check($sformatf("flags_%h_%h", x, y), {27'd0, flags}, {27'd0, ef});
        if (hold > 0) begin
            a = 32'h3F800000;  b = 32'h3F800000;  in_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
        check("busy_after_xfer", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [36:0] m;
        int lat;
        rst = 1'b1;  in_valid = 1'b0;  out_ready = 1'b0;  a = '0;  b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {27'd0, flags}, 32'd0);
        rst = 1'b0;

        m = model(32'h3F800000, 32'h40400000);
        check("pin_model_rne", m[31:0], 32'h3EAAAAAB);
        check("pin_model_rne_flags", {27'd0, m[36:32]}, 32'd1);
        m = model(32'h3F800000, 32'h3FC00000);
        check("pin_model_two_thirds", m[31:0], 32'h3F2AAAAB);
        m = model(32'h7F000000, 32'h3E800000);
        check("pin_model_ovf_flags", {27'd0, m[36:32]}, 32'd5);

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 0);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29, 0);
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2, 0);
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2, 0);
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2, 0);
        run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 29, 0);
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 29, 0);
        run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 2, 0);
        run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 2, 0);
        run_op(32'h80000000, 32'h40A00000, 32'h80000000, 5'b00000, 2, 0);
        run_op(32'h40A00000, 32'h7F800000, 32'h00000000, 5'b00000, 2, 0);
        run_op(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'b00001, 29, 0);
        run_op(32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2, 0);
        run_op(32'h3F800000, 32'h00000001, 32'h7F800000, 5'b01000, 2, 0);
        run_op(32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 5'b00001, 29, 0);
        run_op(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000, 29, 10);

        // Abort an operation in the middle of the iteration phase
        wait_idle();
        a = 32'h3F800000;  b = 32'h40400000;  in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {27'd0, flags}, 32'd0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
